// File: rtl/digseg_scan_ctrl.sv
// Bus slave that time-multiplexes NUM_DIGITS hex digits onto one 7-segment bus.
// Bus ack one cycle after select; outputs registered, lagging scan state by one cycle.
module digseg_scan_ctrl #(
  parameter int          NUM_DIGITS   = 4,
  parameter logic [15:0] SCAN_DIV_RST = 16'd50000,
  parameter logic [7:0]  BLINK_TICKS  = 8'd250,
  parameter bit          COMMON_ANODE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           bus_addr_i,
  input  logic [31:0]           bus_data_i,
  output logic [31:0]           bus_data_o,
  input  logic                  bus_select_i,
  input  logic                  bus_we_i,
  output logic                  bus_ack_o,
  output logic [6:0]            seg_o,
  output logic [NUM_DIGITS-1:0] dig_sel_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW    = 4 * NUM_DIGITS;

  logic                  r_ack;
  logic [31:0]           r_rdata;
  logic [VW-1:0]         r_value;
  logic                  r_en;
  logic                  r_blink_en;
  logic [NUM_DIGITS-1:0] r_blank;
  logic [NUM_DIGITS-1:0] r_blinkm;
  logic [15:0]           r_div;
  logic [15:0]           r_pre;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            r_frm;
  logic                  r_ph;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_dig;

  logic                  w_xfer;
  logic                  w_wr;
  logic                  w_div_wr;
  logic [31:0]           w_rd;
  logic [15:0]           w_div_m1;
  logic                  w_tc;
  logic                  w_wrap;
  logic [3:0]            w_nib;
  logic                  w_off;
  logic [6:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_dig;
  logic                  w_unused;

  assign w_unused = ^{bus_addr_i[31:4], bus_addr_i[1:0], bus_data_i};

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // A transfer is accepted on the edge where ack rises; a held select re-arms every other cycle.
  assign w_xfer   = bus_select_i & ~r_ack;
  assign w_wr     = w_xfer & bus_we_i;
  assign w_div_wr = w_wr & (bus_addr_i[3:2] == 2'd3);

  always_comb begin
    w_rd = '0;
    case (bus_addr_i[3:2])
      2'd0: w_rd[VW-1:0] = r_value;
      2'd1: w_rd[1:0] = {r_blink_en, r_en};
      2'd2: begin
        w_rd[NUM_DIGITS-1:0]    = r_blank;
        w_rd[8 +: NUM_DIGITS]   = r_blinkm;
      end
      default: w_rd[15:0] = r_div;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_xfer;
      r_rdata <= (w_xfer & ~bus_we_i) ? w_rd : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value    <= '0;
      r_en       <= 1'b1;
      r_blink_en <= 1'b0;
      r_blank    <= '0;
      r_blinkm   <= '0;
      r_div      <= SCAN_DIV_RST;
    end else if (w_wr) begin
      case (bus_addr_i[3:2])
        2'd0: r_value <= bus_data_i[VW-1:0];
        2'd1: begin
          r_en       <= bus_data_i[0];
          r_blink_en <= bus_data_i[1];
        end
        2'd2: begin
          r_blank  <= bus_data_i[NUM_DIGITS-1:0];
          r_blinkm <= bus_data_i[8 +: NUM_DIGITS];
        end
        default: r_div <= bus_data_i[15:0];
      endcase
    end
  end

  // DIV of 0 is treated as 1, i.e. the prescaler terminal count is always 0.
  assign w_div_m1 = (r_div == 16'd0) ? 16'd0 : r_div - 16'd1;
  assign w_tc     = r_en & (r_pre == w_div_m1);
  assign w_wrap   = w_tc & (r_idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
      r_frm <= '0;
      r_ph  <= 1'b0;
    end else begin
      if (w_div_wr) begin
        r_pre <= '0;
      end else if (r_en) begin
        r_pre <= w_tc ? 16'd0 : r_pre + 16'd1;
      end
      if (w_tc) begin
        r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
      end
      if (w_wrap) begin
        if (r_frm == BLINK_TICKS - 8'd1) begin
          r_frm <= '0;
          r_ph  <= ~r_ph;
        end else begin
          r_frm <= r_frm + 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_dig = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_dig[i] = (r_idx == IDX_W'(i));
    end
    w_nib = r_value[{r_idx, 2'b00} +: 4];
    w_off = r_blank[r_idx] | (r_blink_en & r_blinkm[r_idx] & r_ph);
    w_seg = w_off ? 7'd0 : hex7(w_nib);
    if (!r_en) begin
      w_seg = '0;
      w_dig = '0;
    end
  end

  // Polarity is applied at the register so reset and "off" are both inactive levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= {7{COMMON_ANODE}};
      r_dig <= {NUM_DIGITS{COMMON_ANODE}};
    end else begin
      r_seg <= w_seg ^ {7{COMMON_ANODE}};
      r_dig <= w_dig ^ {NUM_DIGITS{COMMON_ANODE}};
    end
  end

  assign bus_ack_o  = r_ack;
  assign bus_data_o = r_rdata;
  assign seg_o      = r_seg;
  assign dig_sel_o  = r_dig;

endmodule

// File: tb/tb_digseg_scan_ctrl.sv
// Bench for digseg_scan_ctrl: per-cycle comparison against a slot-count model,
// register table vectors, hand-written scan/blink/handshake sequences and random bus traffic.
module tb_digseg_scan_ctrl;

  localparam int          N    = 4;
  localparam logic [15:0] DIVR = 16'd3;
  localparam int          BT   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   bus_addr_i = '0;
  logic [31:0]   bus_data_i = '0;
  logic [31:0]   bus_data_o;
  logic          bus_select_i = 1'b0;
  logic          bus_we_i = 1'b0;
  logic          bus_ack_o;
  logic [6:0]    seg_o;
  logic [N-1:0]  dig_sel_o;

  always #5 clk = ~clk;

  digseg_scan_ctrl #(
    .NUM_DIGITS(N), .SCAN_DIV_RST(DIVR), .BLINK_TICKS(8'(BT)), .COMMON_ANODE(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i), .bus_data_o(bus_data_o),
    .bus_select_i(bus_select_i), .bus_we_i(bus_we_i), .bus_ack_o(bus_ack_o),
    .seg_o(seg_o), .dig_sel_o(dig_sel_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [6:0] hex_tab [16];
  initial begin
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  end

  // Reference model: scan position is a running count of completed digit slots.
  logic [31:0] m_value, m_blank, m_blinkm;
  logic        m_en, m_ben, m_ack;
  int          m_div, m_pre;
  longint      m_slot;
  logic [6:0]  e_seg;
  logic [N-1:0] e_dig;
  logic [31:0] e_data;
  bit          chk_on = 1'b0;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case ((a >> 2) & 3)
      0: return m_value;
      1: return {30'd0, m_ben, m_en};
      2: return {16'd0, m_blinkm[7:0], m_blank[7:0]};
      default: return 32'(m_div);
    endcase
  endfunction

  always @(posedge clk) begin : model
    int   idx;
    logic xfer;
    bit   ph;
    if (rst) begin
      m_value = 0; m_blank = 0; m_blinkm = 0; m_en = 1; m_ben = 0;
      m_div = int'(DIVR); m_pre = 0; m_slot = 0; m_ack = 0;
      e_seg = 0; e_dig = 0; e_data = 0;
    end else begin
      idx = int'(m_slot % N);
      ph  = ((m_slot / N / BT) % 2) == 1;
      if (m_en) begin
        e_dig = N'(1) << idx;
        if (m_blank[idx] || (m_ben && m_blinkm[idx] && ph)) e_seg = 0;
        else e_seg = hex_tab[(m_value >> (4 * idx)) & 15];
      end else begin
        e_dig = 0;
        e_seg = 0;
      end
      xfer   = bus_select_i && !m_ack;
      e_data = (xfer && !bus_we_i) ? m_read(bus_addr_i) : 32'd0;
      m_ack  = xfer;
      if (m_en) begin
        if (m_pre >= ((m_div == 0) ? 1 : m_div) - 1) begin
          m_pre = 0;
          m_slot++;
        end else begin
          m_pre++;
        end
      end
      if (xfer && bus_we_i) begin
        case ((bus_addr_i >> 2) & 3)
          0: m_value = bus_data_i & 32'((64'd1 << (4 * N)) - 1);
          1: begin m_en = bus_data_i[0]; m_ben = bus_data_i[1]; end
          2: begin
            m_blank  = bus_data_i & ((32'd1 << N) - 1);
            m_blinkm = (bus_data_i >> 8) & ((32'd1 << N) - 1);
          end
          default: begin m_div = int'(bus_data_i & 32'hFFFF); m_pre = 0; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc seg", 32'(seg_o), 32'(e_seg));
      chk("cyc dig", 32'(dig_sel_o), 32'(e_dig));
      chk("cyc ack", 32'(bus_ack_o), 32'(m_ack));
      chk("cyc data", bus_data_o, e_data);
    end
  end

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] q, output int n);
    @(negedge clk);
    bus_select_i = 1'b1; bus_addr_i = a; bus_we_i = w; bus_data_i = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_ack_o && n < 8);
    if (!bus_ack_o) begin
      total++; bad++;
      $display("FAIL bus timeout: no ack within %0d cycles, addr %h", n, a);
    end
    q = bus_data_o;
    bus_select_i = 1'b0; bus_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q; int n;
    bus(a, 1'b1, d, q, n);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    int n;
    bus(a, 1'b0, 32'd0, q, n);
  endtask

  function automatic int dig_to_idx(input logic [N-1:0] d);
    for (int i = 0; i < N; i++) if (d == (N'(1) << i)) return i;
    return -1;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [31:0] q;
    logic [N-1:0] prev;
    logic [6:0] t2_seg [4];
    int n, cnt, c_off, c_on, ix;
    bit found;

    tbl[0] = '{32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_FFFF};
    tbl[1] = '{32'hFFFF_FFF4, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[2] = '{32'h0000_0004, 32'h0000_0002, 32'h0000_0002};
    tbl[3] = '{32'h0000_0008, 32'hFFFF_FFFF, 32'h0000_0F0F};
    tbl[4] = '{32'h0000_0008, 32'h0000_A5A5, 32'h0000_0505};
    tbl[5] = '{32'h0000_000C, 32'h0001_2345, 32'h0000_2345};
    tbl[6] = '{32'h0000_000F, 32'h0000_0000, 32'h0000_0000};
    tbl[7] = '{32'h0000_000C, 32'h0000_0002, 32'h0000_0002};
    tbl[8] = '{32'h0000_0008, 32'h0000_0000, 32'h0000_0000};
    tbl[9] = '{32'h0000_0004, 32'hFFFF_FFFD, 32'h0000_0001};
    t2_seg = '{7'h71, 7'h06, 7'h77, 7'h4F};

    // 1: reset state and reset-value readback
    @(posedge clk);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst seg", 32'(seg_o), 32'd0);
    chk("rst dig", 32'(dig_sel_o), 32'd0);
    chk("rst ack", 32'(bus_ack_o), 32'd0);
    rst = 1'b0;
    bus(32'hC, 1'b0, 32'd0, q, n);
    chk("t1 ack latency", 32'(n), 32'd1);
    chk("t1 DIV reset", q, 32'd3);
    rd(32'h4, q);
    chk("t1 CTRL reset", q, 32'd1);

    // 2: scan order, slot length and hex decode
    wr(32'h0, 32'h0000_3A1F);
    prev = dig_sel_o; found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (dig_sel_o == 1 && prev != 1) found = 1;
      else prev = dig_sel_o;
    end
    chk("t2 sync", 32'(found), 32'd1);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      chk("t2 dig", 32'(dig_sel_o), 32'(N'(1) << ((k / 3) % 4)));
      chk("t2 seg", 32'(seg_o), 32'(t2_seg[(k / 3) % 4]));
    end

    // 3: blank mask on digit 1
    wr(32'h8, 32'h0000_0002);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ix = dig_to_idx(dig_sel_o);
      if (ix == 1) chk("t3 blanked", 32'(seg_o), 32'd0);
      else if (ix >= 0) chk("t3 shown", 32'(seg_o), 32'(t2_seg[ix]));
    end
    rd(32'h8, q);
    chk("t3 MASK read", q, 32'h0000_0002);

    // 4: blinking digit 0 shows both phases
    wr(32'h4, 32'h3);
    wr(32'h8, 32'h0000_0100);
    c_off = 0; c_on = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (dig_sel_o == 1 && seg_o == 7'h00) c_off++;
      if (dig_sel_o == 1 && seg_o == 7'h71) c_on++;
    end
    chk("t4 blink off seen", 32'(c_off > 0), 32'd1);
    chk("t4 blink on seen", 32'(c_on > 0), 32'd1);

    // 5: DIV=0 advances every cycle; EN=0 freezes and blanks
    wr(32'hC, 32'h0);
    repeat (2) @(negedge clk);
    prev = dig_sel_o;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5 fast scan", 32'(dig_sel_o), 32'({prev[N-2:0], prev[N-1]}));
      prev = dig_sel_o;
    end
    wr(32'h4, 32'h2);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5 off seg", 32'(seg_o), 32'd0);
      chk("t5 off dig", 32'(dig_sel_o), 32'd0);
    end
    wr(32'h4, 32'h1);
    repeat (6) @(negedge clk);

    // 6: held select, and reset landing on a write's commit edge
    wr(32'hC, 32'h3);
    @(negedge clk);
    bus_select_i = 1'b1; bus_addr_i = 32'h4; bus_we_i = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_ack_o) cnt++;
    end
    bus_select_i = 1'b0;
    chk("t6 held acks", 32'(cnt), 32'd3);
    @(negedge clk);
    @(negedge clk);
    bus_select_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = 32'h0; bus_data_i = 32'h5555;
    rst = 1'b1;
    @(negedge clk);
    chk("t6 rst ack", 32'(bus_ack_o), 32'd0);
    rst = 1'b0; bus_select_i = 1'b0; bus_we_i = 1'b0;
    rd(32'h0, q);
    chk("t6 write dropped", q, 32'd0);

    // Register write/readback vectors
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr, q);
      chk($sformatf("vec%0d", i), q, tbl[i].exp);
    end

    // Random bus traffic, checked cycle by cycle against the model
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 299) == 0);
      bus_select_i = ($urandom_range(0, 2) != 0);
      bus_we_i     = $urandom_range(0, 1) == 1;
      bus_addr_i   = $urandom;
      if (bus_addr_i[3:2] == 2'd3) bus_data_i = $urandom_range(0, 4);
      else bus_data_i = $urandom;
    end
    @(negedge clk);
    rst = 1'b0; bus_select_i = 1'b0; bus_we_i = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
